nice_cfg_master: RTL and testbench

NICE_CFG_MASTER -- requirements
Module: nice_cfg_master

---
 rtl/nice_cfg_pkg.sv | 29 ++
 rtl/nice_cfg_fifo.sv | 55 +++++
 rtl/nice_cfg_master.sv | 134 +++++++++++++
 tb/tb_nice_cfg_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nice_cfg_pkg.sv
// Shared types and constants for the NICE configuration master.
// No logic: state encoding, command record, opcode/funct3 values, instruction builder.
// Backpressure: n/a.
package nice_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [6:0]  OPCODE_CUSTOM1 = 7'b0101011;
  localparam logic [2:0]  FUNCT3_CFG     = 3'b011;
  localparam logic [2:0]  FUNCT3_START   = 3'b010;
  localparam logic [31:0] TIMEOUT_DAT    = 32'hDEAD_0000;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } cmd_t;

  // R-type layout with rd/rs1/rs2 register fields zeroed; operands travel on the rs buses.
  function automatic logic [31:0] build_instr(input cmd_t c, input logic [6:0] opcode);
    return {c.funct7, 5'b0, 5'b0, c.funct3, 5'b0, opcode};
  endfunction

endpackage

// File: rtl/nice_cfg_fifo.sv
// Synchronous FIFO of command records, DEPTH a power of two >= 2.
// Latency: one cycle from push edge to non-empty; head is read combinationally.
// Backpressure: full blocks further pushes; push while full and pop while empty are ignored.
module nice_cfg_fifo
  import nice_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_dat,
  input  logic pop,
  output cmd_t pop_dat,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  cmd_t          mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/nice_cfg_master.sv
// Queues config/start commands and issues them one at a time on the NICE request/response channel.
// Latency: push into empty idle FIFO -> nice_req_valid high after the next edge; rsp_valid one cycle after response accept.
// Backpressure: cmd_ready low when FIFO full; request held until nice_req_ready; optional RSP timeout with NICE_CFG_TIMEOUT_EN.
module nice_cfg_master
  import nice_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  OPCODE     = OPCODE_CUSTOM1
) (
  input  logic        nice_clk,
  input  logic        nice_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_funct7,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        nice_req_valid,
  input  logic        nice_req_ready,
  output logic [31:0] nice_req_instr,
  output logic [31:0] nice_req_rs1,
  output logic [31:0] nice_req_rs2,
  input  logic        nice_rsp_multicyc_valid,
  output logic        nice_rsp_multicyc_ready,
  input  logic [31:0] nice_rsp_multicyc_dat,
  input  logic        nice_rsp_multicyc_err,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy
);

  state_t state;
  cmd_t   push_dat;
  cmd_t   head_dat;
  logic   fifo_full;
  logic   fifo_empty;
  logic   cmd_push;
  logic   cmd_pop;
  logic   init_done;

  assign push_dat  = '{funct7: cmd_funct7, funct3: cmd_funct3, rs1: cmd_rs1, rs2: cmd_rs2};
  assign cmd_ready = init_done & ~fifo_full;
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_pop   = (state == ST_IDLE) & ~fifo_empty;
  assign busy      = ~fifo_empty | (state != ST_IDLE);

  nice_cfg_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (nice_clk),
    .rst      (nice_rst),
    .push     (cmd_push),
    .push_dat (push_dat),
    .pop      (cmd_pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Keeps cmd_ready low while reset is held and until the first edge after release.
  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) init_done <= 1'b0;
    else          init_done <= 1'b1;
  end

`ifdef NICE_CFG_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) begin
      state                   <= ST_IDLE;
      nice_req_valid          <= 1'b0;
      nice_req_instr          <= '0;
      nice_req_rs1            <= '0;
      nice_req_rs2            <= '0;
      nice_rsp_multicyc_ready <= 1'b0;
      rsp_valid               <= 1'b0;
      rsp_dat                 <= '0;
      rsp_err                 <= 1'b0;
`ifdef NICE_CFG_TIMEOUT_EN
      to_cnt                  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            nice_req_instr <= build_instr(head_dat, OPCODE);
            nice_req_rs1   <= head_dat.rs1;
            nice_req_rs2   <= head_dat.rs2;
            nice_req_valid <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Response ready only rises here, so a response coincident with this handshake is not seen.
          if (nice_req_valid && nice_req_ready) begin
            nice_req_valid          <= 1'b0;
            nice_rsp_multicyc_ready <= 1'b1;
            state                   <= ST_RSP;
`ifdef NICE_CFG_TIMEOUT_EN
            to_cnt                  <= '0;
`endif
          end
        end
        ST_RSP: begin
          if (nice_rsp_multicyc_valid && nice_rsp_multicyc_ready) begin
            rsp_dat                 <= nice_rsp_multicyc_dat;
            rsp_err                 <= nice_rsp_multicyc_err;
            rsp_valid               <= 1'b1;
            nice_rsp_multicyc_ready <= 1'b0;
            state                   <= ST_IDLE;
          end
`ifdef NICE_CFG_TIMEOUT_EN
          // Counter starts at 0 on entry, so the 255th silent RSP cycle gives up.
          else if (to_cnt == 8'd254) begin
            rsp_dat                 <= TIMEOUT_DAT;
            rsp_err                 <= 1'b1;
            rsp_valid               <= 1'b1;
            nice_rsp_multicyc_ready <= 1'b0;
            state                   <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nice_cfg_master.sv
// Self-checking bench for nice_cfg_master: directed steps plus randomized traffic against a command queue model.
// Covers NICE_CFG_TIMEOUT_EN when that macro is defined for the build.
module tb_nice_cfg_master;
  import nice_cfg_pkg::*;

  logic        nice_clk = 1'b0;
  logic        nice_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_funct7;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        nice_req_valid;
  logic        nice_req_ready;
  logic [31:0] nice_req_instr;
  logic [31:0] nice_req_rs1;
  logic [31:0] nice_req_rs2;
  logic        nice_rsp_multicyc_valid;
  logic        nice_rsp_multicyc_ready;
  logic [31:0] nice_rsp_multicyc_dat;
  logic        nice_rsp_multicyc_err;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];

  always #5 nice_clk = ~nice_clk;

  nice_cfg_master dut (
    .nice_clk                (nice_clk),
    .nice_rst                (nice_rst),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_funct7              (cmd_funct7),
    .cmd_funct3              (cmd_funct3),
    .cmd_rs1                 (cmd_rs1),
    .cmd_rs2                 (cmd_rs2),
    .nice_req_valid          (nice_req_valid),
    .nice_req_ready          (nice_req_ready),
    .nice_req_instr          (nice_req_instr),
    .nice_req_rs1            (nice_req_rs1),
    .nice_req_rs2            (nice_req_rs2),
    .nice_rsp_multicyc_valid (nice_rsp_multicyc_valid),
    .nice_rsp_multicyc_ready (nice_rsp_multicyc_ready),
    .nice_rsp_multicyc_dat   (nice_rsp_multicyc_dat),
    .nice_rsp_multicyc_err   (nice_rsp_multicyc_err),
    .rsp_valid               (rsp_valid),
    .rsp_dat                 (rsp_dat),
    .rsp_err                 (rsp_err),
    .busy                    (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction word from field arithmetic: funct7 at bit 25, funct3 at bit 12, opcode 0x2B.
  function automatic logic [31:0] exp_instr(input cmd_t c);
    return 32'(c.funct7) * 32'h0200_0000 + 32'(c.funct3) * 32'h0000_1000 + 32'h0000_002B;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.funct7 = 7'($urandom);
    c.funct3 = 3'($urandom);
    c.rs1    = $urandom;
    c.rs2    = $urandom;
    return c;
  endfunction

  // Called at a negedge; returns at a negedge with cmd_valid low.
  task automatic push(input cmd_t c);
    int n;
    n = 0;
    cmd_valid  = 1'b1;
    cmd_funct7 = c.funct7;
    cmd_funct3 = c.funct3;
    cmd_rs1    = c.rs1;
    cmd_rs2    = c.rs2;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge nice_clk);
      n++;
    end
    chk("push_ready_wait", {31'b0, cmd_ready}, 32'd1);
    @(posedge nice_clk);
    exp_q.push_back(c);
    @(negedge nice_clk);
    cmd_valid = 1'b0;
  endtask

  // Plays the accelerator for one command. lat < 0 leaves the DUT waiting in RSP.
  task automatic serve(input int bp, input int lat, input logic [31:0] dat, input logic err, input bit early);
    cmd_t        e;
    logic [31:0] ei;
    int          n;
    n = 0;
    while (nice_req_valid !== 1'b1 && n < 60) begin
      @(negedge nice_clk);
      n++;
    end
    chk("req_valid_wait", {31'b0, nice_req_valid}, 32'd1);
    chk("model_has_cmd", {31'b0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    ei = exp_instr(e);
    for (int i = 0; i < bp; i++) begin
      chk("bp_req_valid", {31'b0, nice_req_valid}, 32'd1);
      chk("bp_instr", nice_req_instr, ei);
      chk("bp_rs1", nice_req_rs1, e.rs1);
      chk("bp_rs2", nice_req_rs2, e.rs2);
      chk("bp_rsp_ready", {31'b0, nice_rsp_multicyc_ready}, 32'd0);
      @(negedge nice_clk);
    end
    chk("req_instr", nice_req_instr, ei);
    chk("req_rs1", nice_req_rs1, e.rs1);
    chk("req_rs2", nice_req_rs2, e.rs2);
    nice_req_ready = 1'b1;
    if (early) begin
      nice_rsp_multicyc_valid = 1'b1;
      nice_rsp_multicyc_dat   = ~dat;
      nice_rsp_multicyc_err   = ~err;
    end
    @(negedge nice_clk);
    nice_req_ready          = 1'b0;
    nice_rsp_multicyc_valid = 1'b0;
    chk("rsp_ready_in_rsp", {31'b0, nice_rsp_multicyc_ready}, 32'd1);
    chk("req_valid_in_rsp", {31'b0, nice_req_valid}, 32'd0);
    chk("no_early_rsp", {31'b0, rsp_valid}, 32'd0);
    if (lat < 0) return;
    repeat (lat) @(negedge nice_clk);
    nice_rsp_multicyc_valid = 1'b1;
    nice_rsp_multicyc_dat   = dat;
    nice_rsp_multicyc_err   = err;
    n = 0;
    while (nice_rsp_multicyc_ready !== 1'b1 && n < 60) begin
      @(negedge nice_clk);
      n++;
    end
    @(negedge nice_clk);
    nice_rsp_multicyc_valid = 1'b0;
    chk("rsp_valid_pulse", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_dat", rsp_dat, dat);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    chk("rsp_ready_after", {31'b0, nice_rsp_multicyc_ready}, 32'd0);
    @(negedge nice_clk);
    chk("rsp_valid_one_cycle", {31'b0, rsp_valid}, 32'd0);
    chk("rsp_dat_held", rsp_dat, dat);
  endtask

  initial begin
    cmd_t c;
    int   n;
    bit   seen;
    nice_rst = 1'b1;
    cmd_valid = 1'b0; cmd_funct7 = '0; cmd_funct3 = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    nice_req_ready = 1'b0;
    nice_rsp_multicyc_valid = 1'b0; nice_rsp_multicyc_dat = '0; nice_rsp_multicyc_err = 1'b0;

    // Reset state
    repeat (3) @(negedge nice_clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_req_valid", {31'b0, nice_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'b0, nice_rsp_multicyc_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    nice_rst = 1'b0;
    #1 chk("cmd_ready_before_edge", {31'b0, cmd_ready}, 32'd0);
    @(negedge nice_clk);
    chk("cmd_ready_after_edge", {31'b0, cmd_ready}, 32'd1);

    // Single command with issue-latency check
    c = '{funct7: 7'h01, funct3: FUNCT3_CFG, rs1: 32'd1, rs2: 32'd2};
    cmd_valid = 1'b1; cmd_funct7 = c.funct7; cmd_funct3 = c.funct3; cmd_rs1 = c.rs1; cmd_rs2 = c.rs2;
    @(posedge nice_clk);
    exp_q.push_back(c);
    @(negedge nice_clk);
    cmd_valid = 1'b0;
    chk("lat_valid_low_edge1", {31'b0, nice_req_valid}, 32'd0);
    chk("busy_after_push", {31'b0, busy}, 32'd1);
    @(negedge nice_clk);
    chk("lat_valid_high_edge2", {31'b0, nice_req_valid}, 32'd1);
    chk("single_instr", nice_req_instr, 32'h0200_302B);
    serve(0, 3, 32'd5, 1'b0, 1'b0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Back-pressure, plus a response coinciding with the request handshake
    push(rand_cmd());
    serve(5, 1, $urandom, 1'b0, 1'b1);

    // Error response held until next completion
    push(rand_cmd());
    serve(0, 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (6) @(negedge nice_clk);
    chk("err_held", {31'b0, rsp_err}, 32'd1);
    chk("err_dat_held", rsp_dat, 32'hFFFF_FFFF);

`ifdef NICE_CFG_TIMEOUT_EN
    push(rand_cmd());
    serve(0, -1, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(posedge nice_clk);
      #1 n++;
    end
    chk("timeout_cycles", n, 32'd255);
    chk("timeout_err", {31'b0, rsp_err}, 32'd1);
    chk("timeout_dat", rsp_dat, 32'hDEAD_0000);
    @(negedge nice_clk);
    chk("timeout_idle_busy", {31'b0, busy}, 32'd0);
    push(rand_cmd());
    serve(0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
`endif

    // Reset while waiting in RSP
    push(rand_cmd());
    serve(0, -1, 32'd0, 1'b0, 1'b0);
    seen = 1'b0;
`ifdef NICE_CFG_TIMEOUT_EN
    repeat (20) begin
`else
    repeat (300) begin
`endif
      @(negedge nice_clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    chk("rsp_waits", {31'b0, seen}, 32'd0);
    chk("rsp_wait_busy", {31'b0, busy}, 32'd1);
    #2 nice_rst = 1'b1;
    #1;
    chk("midrst_req_valid", {31'b0, nice_req_valid}, 32'd0);
    chk("midrst_rsp_ready", {31'b0, nice_rsp_multicyc_ready}, 32'd0);
    chk("midrst_rsp_dat", rsp_dat, 32'd0);
    chk("midrst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_instr", nice_req_instr, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge nice_clk);
    nice_rst = 1'b0;
    @(negedge nice_clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    push(rand_cmd());
    serve(1, 2, $urandom, 1'b0, 1'b0);

    // Full: 6 back-to-back attempts with the accelerator stalled.
    // The first command leaves the FIFO into the request registers, so 4 more fill it.
    for (int i = 0; i < 6; i++) begin
      c = rand_cmd();
      cmd_valid = 1'b1; cmd_funct7 = c.funct7; cmd_funct3 = c.funct3; cmd_rs1 = c.rs1; cmd_rs2 = c.rs2;
      chk("full_cmd_ready", {31'b0, cmd_ready}, {31'b0, i < 5});
      @(posedge nice_clk);
      if (i < 5) exp_q.push_back(c);
      @(negedge nice_clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge nice_clk);
    chk("full_stays_full", {31'b0, cmd_ready}, 32'd0);
    for (int i = 0; i < 5; i++) serve($urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'(i), 1'b0);
    repeat (4) @(negedge nice_clk);
    chk("full_drained_busy", {31'b0, busy}, 32'd0);
    chk("full_drained_valid", {31'b0, nice_req_valid}, 32'd0);

    // Config sequence: one-hot register selects then start
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          c.funct7 = 7'(1 << i);
          c.funct3 = (i == 6) ? FUNCT3_START : FUNCT3_CFG;
          c.rs1    = $urandom;
          c.rs2    = $urandom;
          push(c);
        end
      end
      begin
        for (int j = 0; j < 7; j++) serve(0, 1, $urandom, 1'b0, 1'b0);
      end
    join
    chk("cfg_last_instr", nice_req_instr, 32'h8000_202B);

    // Randomized traffic
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge nice_clk);
          push(rand_cmd());
        end
      end
      begin
        for (int j = 0; j < 24; j++)
          serve($urandom_range(0, 4), $urandom_range(0, 6), $urandom, 1'($urandom), ($urandom_range(0, 3) == 0));
      end
    join
    repeat (4) @(negedge nice_clk);
    chk("final_busy", {31'b0, busy}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
